// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : opcodes, funct3 codes, address regions and MMIO map for the
//             three-stage RISC-V pipeline.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] REGION_DMEM      = 4'b0001;
  localparam logic [3:0] REGION_IMEM      = 4'b0010;
  localparam logic [3:0] REGION_DMEM_IMEM = 4'b0011;
  localparam logic [3:0] REGION_BIOS      = 4'b0100;
  localparam logic [3:0] REGION_MMIO      = 4'b1000;

  localparam logic [31:0] MMIO_UART_CTRL = 32'h8000_0000;
  localparam logic [31:0] MMIO_UART_RX   = 32'h8000_0004;
  localparam logic [31:0] MMIO_UART_TX   = 32'h8000_0008;
  localparam logic [31:0] MMIO_CYCLE     = 32'h8000_0010;
  localparam logic [31:0] MMIO_INSTRET   = 32'h8000_0014;
  localparam logic [31:0] MMIO_CNT_CLR   = 32'h8000_0018;

  function automatic logic writes_rd(input logic [6:0] opc);
    return (opc == OPC_LOAD)  || (opc == OPC_OPIMM) || (opc == OPC_OP)  ||
           (opc == OPC_LUI)   || (opc == OPC_AUIPC) || (opc == OPC_JAL) ||
           (opc == OPC_JALR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
// ============================================================================
// mem_wb_stage_if : memory (DMEM/BIOS/IMEM) and UART ports of the MW stage.
// Revision        : 1.0
// ============================================================================
`default_nettype none

interface mem_wb_stage_if;
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [13:0] dmem_addr;
  logic [31:0] dmem_din;
  logic [31:0] dmem_dout;
  logic        bios_enb;
  logic [11:0] bios_addrb;
  logic [31:0] bios_doutb;
  logic        imem_ena;
  logic [3:0]  imem_wea;
  logic [13:0] imem_addra;
  logic [31:0] imem_dina;
  logic [7:0]  uart_rx_data_out;
  logic        uart_rx_data_out_valid;
  logic        uart_rx_data_out_ready;
  logic [7:0]  uart_tx_data_in;
  logic        uart_tx_data_in_valid;
  logic        uart_tx_data_in_ready;

  modport master (
    output dmem_en, dmem_we, dmem_addr, dmem_din,
    input  dmem_dout,
    output bios_enb, bios_addrb,
    input  bios_doutb,
    output imem_ena, imem_wea, imem_addra, imem_dina,
    input  uart_rx_data_out, uart_rx_data_out_valid,
    output uart_rx_data_out_ready,
    output uart_tx_data_in, uart_tx_data_in_valid,
    input  uart_tx_data_in_ready
  );

  modport slave (
    input  dmem_en, dmem_we, dmem_addr, dmem_din,
    output dmem_dout,
    input  bios_enb, bios_addrb,
    output bios_doutb,
    input  imem_ena, imem_wea, imem_addra, imem_dina,
    output uart_rx_data_out, uart_rx_data_out_valid,
    input  uart_rx_data_out_ready,
    input  uart_tx_data_in, uart_tx_data_in_valid,
    output uart_tx_data_in_ready
  );
endinterface

`default_nettype wire

// File: rtl/load_extend.sv
// ============================================================================
// load_extend : selects byte/half/word from a loaded word and extends it.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = word >> {off, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'b0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'b0, half_sel};
      default: result = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// mem_wb_stage : memory/writeback stage - memory and MMIO issue, MW registers,
//                load extension, writeback. Optional macro MMIO_COUNTERS_EN.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  x_valid,
  input  logic [31:0]           x_inst,
  input  logic [31:0]           x_pc,
  input  logic [31:0]           x_alu,
  input  logic [31:0]           x_rs2,
  mem_wb_stage_if.master        bus,
  output logic                  wb_we,
  output logic [4:0]            wb_wa,
  output logic [31:0]           wb_wd
);

  logic        go, is_load, is_store, dmem_hit, imem_hit, mmio_ld, mmio_st;
  logic [3:0]  region, st_mask;
  logic [31:0] st_data, cycle_cnt, instret_cnt;

  logic [31:0] inst_d, inst_q, pc_d, pc_q, alu_d, alu_q, io_rdata_d, io_rdata_q;
  logic        valid_d, valid_q;

  logic [31:0] ld_word, ld_data;

  // ---------------- X cycle: access issue ----------------
  always_comb begin
    go       = x_valid & ~rst;
    is_load  = (x_inst[6:0] == OPC_LOAD);
    is_store = (x_inst[6:0] == OPC_STORE);
    region   = x_alu[31:28];
    dmem_hit = (region == REGION_DMEM) || (region == REGION_DMEM_IMEM);
    imem_hit = ((region == REGION_IMEM) || (region == REGION_DMEM_IMEM)) && x_pc[30];
    mmio_ld  = go & is_load  & (region == REGION_MMIO);
    mmio_st  = go & is_store & (region == REGION_MMIO);

    st_mask = 4'b1111;
    st_data = x_rs2;
    case (x_inst[14:12])
      F3_B: begin
        st_mask = 4'b0001 << x_alu[1:0];
        st_data = {4{x_rs2[7:0]}};
      end
      F3_H: begin
        st_mask = 4'b0011 << {x_alu[1], 1'b0};
        st_data = {2{x_rs2[15:0]}};
      end
      default: ;
    endcase

    bus.dmem_en   = go & dmem_hit & (is_load | is_store);
    bus.dmem_we   = (go & dmem_hit & is_store) ? st_mask : 4'b0000;
    bus.dmem_addr = x_alu[15:2];
    bus.dmem_din  = st_data;

    bus.bios_enb   = go & (region == REGION_BIOS) & is_load;
    bus.bios_addrb = x_alu[13:2];

    bus.imem_ena   = go & imem_hit & is_store;
    bus.imem_wea   = (go & imem_hit & is_store) ? st_mask : 4'b0000;
    bus.imem_addra = x_alu[15:2];
    bus.imem_dina  = st_data;

    bus.uart_rx_data_out_ready = mmio_ld & (x_alu == MMIO_UART_RX);
    // tx_valid is not gated by ready: a store while busy is simply lost
    bus.uart_tx_data_in_valid  = mmio_st & (x_alu == MMIO_UART_TX);
    bus.uart_tx_data_in        = x_rs2[7:0];

    io_rdata_d = 32'b0;
    if (mmio_ld) begin
      case (x_alu)
        MMIO_UART_CTRL: io_rdata_d = {30'b0, bus.uart_rx_data_out_valid, bus.uart_tx_data_in_ready};
        MMIO_UART_RX:   io_rdata_d = {24'b0, bus.uart_rx_data_out};
        MMIO_CYCLE:     io_rdata_d = cycle_cnt;
        MMIO_INSTRET:   io_rdata_d = instret_cnt;
        default:        io_rdata_d = 32'b0;
      endcase
    end

    inst_d  = x_inst;
    pc_d    = x_pc;
    alu_d   = x_alu;
    valid_d = x_valid;
  end

  // ---------------- Counters ----------------
`ifdef MMIO_COUNTERS_EN
  logic        cnt_clr;
  logic [31:0] cycle_d, cycle_q, instret_d, instret_q;

  always_comb begin
    cnt_clr   = mmio_st & (x_alu == MMIO_CNT_CLR);
    cycle_d   = cycle_q + 32'd1;
    instret_d = instret_q + {31'b0, valid_q};
    if (cnt_clr) begin
      cycle_d   = 32'b0;
      instret_d = 32'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 32'b0;
      instret_q <= 32'b0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = 32'b0;
  assign instret_cnt = 32'b0;
`endif

  // ---------------- MW pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q     <= 32'b0;
      pc_q       <= RESET_PC;
      alu_q      <= 32'b0;
      valid_q    <= 1'b0;
      io_rdata_q <= 32'b0;
    end else begin
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      alu_q      <= alu_d;
      valid_q    <= valid_d;
      io_rdata_q <= io_rdata_d;
    end
  end

  // ---------------- MW cycle: load data and writeback ----------------
  always_comb begin
    case (alu_q[31:28])
      REGION_DMEM, REGION_DMEM_IMEM: ld_word = bus.dmem_dout;
      REGION_BIOS:                   ld_word = bus.bios_doutb;
      REGION_MMIO:                   ld_word = io_rdata_q;
      default:                       ld_word = 32'b0;
    endcase
  end

  load_extend u_load_extend (
    .word   (ld_word),
    .off    (alu_q[1:0]),
    .funct3 (inst_q[14:12]),
    .result (ld_data)
  );

  always_comb begin
    wb_wa = inst_q[11:7];
    wb_wd = alu_q;
    if (inst_q[6:0] == OPC_LOAD) begin
      wb_wd = ld_data;
    end else if ((inst_q[6:0] == OPC_JAL) || (inst_q[6:0] == OPC_JALR)) begin
      wb_wd = pc_q + 32'd4;
    end
    wb_we = ~rst & valid_q & writes_rd(inst_q[6:0]) & (inst_q[11:7] != 5'd0);
  end

endmodule

`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory/writeback stage of the three-stage RISC-V pipeline, directly downstream of execute. It issues data-memory, BIOS, IMEM-write and MMIO accesses from the execute-stage address. It holds the MW pipeline registers, extracts and sign-extends load data, and produces the register-file writeback. It also owns the UART MMIO handshake and the cycle and instruction counters.

## Interface
Parameters:
- `RESET_PC`, 32'h4000_0000: reset value of the MW PC register.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `x_valid`  in  1  execute stage holds a real instruction (0 = bubble)
- `x_inst`  in  32  execute-stage instruction
- `x_pc`  in  32  execute-stage PC
- `x_alu`  in  32  ALU result (load/store address)
- `x_rs2`  in  32  forwarded store data
- `dmem_en`, `dmem_we`, `dmem_addr`, `dmem_din`  out  1/4/14/32  DMEM port
- `dmem_dout`  in  32  DMEM read data, valid in MW cycle
- `bios_enb`, `bios_addrb`  out  1/12  BIOS data port
- `bios_doutb`  in  32  BIOS read data
- `imem_ena`, `imem_wea`, `imem_addra`, `imem_dina`  out  1/4/14/32  IMEM write port
- `uart_rx_data_out`  in  8; `uart_rx_data_out_valid`  in  1; `uart_rx_data_out_ready`  out  1
- `uart_tx_data_in`  out  8; `uart_tx_data_in_valid`  out  1; `uart_tx_data_in_ready`  in  1
- `wb_we`  out  1  register-file write enable
- `wb_wa`  out  5  destination register
- `wb_wd`  out  32  writeback data (also the forwarding source for decode)

## Operation
- X cycle, combinational, gated by `x_valid & ~rst`. Region is `x_alu[31:28]`:
  - 0001 or 0011: DMEM.
  - 0100: BIOS read.
  - 0010 or 0011: IMEM write, only when `x_pc[30]`=1.
  - 1000: MMIO.
- Memory addresses are `x_alu[15:2]` and `x_alu[13:2]`.
- Store masks use byte offset `off = x_alu[1:0]`:
  - SB: `we = 4'b0001<<off`, data is `rs2[7:0]` replicated ×4.
  - SH: `we = 4'b0011<<(2*x_alu[1])`, data is `rs2[15:0]` replicated ×2.
  - SW: `we = 4'b1111`.
- Loads assert `en` with `we = 0`.
- MMIO reads are registered at the X→MW edge into `io_rdata_mw`:
  - 0x8000_0000: `{30'b0, rx_valid, tx_ready}`.
  - 0x8000_0004: `{24'b0, rx_data}`; asserts `uart_rx_data_out_ready` for that one cycle.
  - 0x8000_0010: cycle counter.
  - 0x8000_0014: instruction counter.
  - Any other MMIO address: 0.
- MMIO stores:
  - 0x8000_0008: `uart_tx_data_in_valid`=1 for one cycle with `rs2[7:0]`. The store is dropped if tx is not ready; software polls first.
  - 0x8000_0018: clears both counters.
- MW registers: `inst_mw`, `pc_mw`, `alu_mw`, `valid_mw`, `io_rdata_mw`.
- MW load data is selected by `alu_mw[31:28]`: DMEM, BIOS, or `io_rdata_mw`.
- Load extraction by funct3:
  - LB/LBU: byte `alu_mw[1:0]`.
  - LH/LHU: half `alu_mw[1]`.
  - LW: full word.
  - Sign- or zero-extend to 32 bits.
- Writeback data:
  - Loads: extracted load data.
  - JAL/JALR: `pc_mw+4`.
  - Others: `alu_mw`.
- `wb_we = valid_mw & writes_rd(opcode) & (rd != 0)`. Stores, branches and bubbles never write.
- Cycle counter increments every cycle. Instruction counter increments when `valid_mw`=1.
- A counter-clear store takes priority over the increment: the counter reads 0 on the next cycle.

## Timing
- Memory read latency is 1 cycle: address in X, data in MW. Writeback is combinational in MW; the register file latches on the following edge.
- Reset values: all MW registers 0, `pc_mw=RESET_PC`, `valid_mw=0`, counters 0. All enables, `wb_we`, `uart_*_ready/valid` are 0 while `rst` is high.
- Reset mid-operation: a store in X during the `rst` cycle must not write memory or UART. The MW instruction is discarded.
- Bubble (`x_valid=0`): no memory enable, no UART pulse, no counter clear. `valid_mw` becomes 0.
- Consecutive UART reads pop one byte per read. A read while `rx_valid`=0 returns stale data and still pulses ready, which the UART ignores.
- Counters are 32 bits and wrap 0xFFFF_FFFF→0.

## Configuration
- `MMIO_COUNTERS_EN`:
  - Defined: cycle and instruction counters and the clear register are present.
  - Undefined: counters are not instantiated, 0x8000_0010 and 0x8000_0014 read 0, and 0x8000_0018 stores are ignored.

## Structure
- Shared package `riscv_pkg`: opcode and funct3 constants, region codes, MMIO address constants.
- One sub-module, `load_extend`: combinational word, offset and funct3 in; 32-bit result out.

## Test plan
- SB, `x_alu=0x1000_0001`, `rs2=0x0000_00AB` → `dmem_we=4'b0010`, `dmem_din=0xABAB_ABAB`, `dmem_addr=0`.
- LB at 0x1000_0001 with `dmem_dout=0x0000_80FF`: expect `wb_wd=0xFFFF_FF80`. LBU at the same address: expect `wb_wd=0x0000_0080`. LHU at 0x1000_0002 with `dmem_dout=0x9876_0000`: expect `wb_wd=0x0000_9876`.
- SW to 0x2000_0004 with `x_pc=0x1000_0000` → `imem_wea=0`. With `x_pc=0x4000_0000` → `imem_wea=4'hF`, `imem_addra=1`.
- LW 0x8000_0004 with rx byte 0x5A → `uart_rx_data_out_ready` pulses for 1 cycle. Next cycle `wb_wd=0x0000_005A` and `wb_we=1`.
- Run 10 cycles with 6 valid instructions, then store to 0x8000_0018 → next cycle the counters read 0. Without `MMIO_COUNTERS_EN`, the reads always return 0.
- JAL at `pc_mw=0x4000_0010` with rd=1 → `wb_wd=0x4000_0014`. Same instruction with rd=0 → `wb_we=0`. Assert `rst` with SW in X → no enables asserted.
